// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
// Row-scan sequencer for an 8x8 LED matrix. Fetches one row of pixels at a
// time from a double-buffered frame store, lights it for DWELL_CYCLES, then
// moves to the next row. Front/back buffer swaps are taken only at the frame
// boundary (end of row 7) so a frame is never shown torn.
//
// Optional feature macro: LED_MATRIX_BLANK_EN
//   defined   : BLANK_CYCLES dark cycles are inserted between FETCH and SHOW
//               on every row to suppress ghosting.
//   undefined : FETCH goes straight to SHOW.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   rd_req      out  row fetch request, held until rd_valid is sampled
//   rd_addr     out  {buf_sel, row_idx[2:0]}
//   rd_data     in   row pixels, bit n drives col[n]
//   rd_valid    in   fetch complete, rd_data valid this cycle
//   swap_req    in   single-cycle buffer swap request
//   swap_ack    out  single-cycle pulse when the swap takes effect
//   buf_sel     out  buffer being displayed (writer uses ~buf_sel)
//   frame_start out  pulse on the first FETCH cycle of row 0
//   row         out  one-hot active-high row select, zero when dark
//   col         out  active-high column data, zero when dark
//
// All outputs are registered from next-state values, so they line up with
// the state that the same edge enters.

module led_matrix_scanner #(
    parameter int DWELL_CYCLES = 27000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    output logic       rd_req,
    output logic [3:0] rd_addr,
    input  logic [7:0] rd_data,
    input  logic       rd_valid,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       buf_sel,
    output logic       frame_start,
    output logic [7:0] row,
    output logic [7:0] col
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
`ifdef LED_MATRIX_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        RESET_IDLE = 2'd0,
        FETCH      = 2'd1,
        BLANK      = 2'd2,
        SHOW       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       row_idx_q, row_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             buf_sel_q, buf_sel_d;
    logic             swap_pending_q, swap_pending_d;
    logic             swap_now;
    logic             dwell_done;
    logic             frame_start_d;

    logic             rd_req_q;
    logic [3:0]       rd_addr_q;
    logic             swap_ack_q;
    logic             frame_start_q;
    logic [7:0]       row_q;
    logic [7:0]       col_q;

    always_comb begin
        state_d        = state_q;
        row_idx_d      = row_idx_q;
        cnt_d          = cnt_q;
        data_d         = data_q;
        buf_sel_d      = buf_sel_q;
        swap_pending_d = swap_pending_q;

        dwell_done = (cnt_q == DWELL_LAST);

        // A request arriving in the boundary cycle itself is honoured there;
        // extra requests while one is pending simply merge into it.
        swap_now = (state_q == SHOW) && dwell_done && (row_idx_q == 3'd7)
                   && (swap_pending_q || swap_req);
        if (swap_now) begin
            buf_sel_d      = ~buf_sel_q;
            swap_pending_d = 1'b0;
        end else if (swap_req) begin
            swap_pending_d = 1'b1;
        end

        case (state_q)
            RESET_IDLE: begin
                state_d   = FETCH;
                row_idx_d = 3'd0;
                cnt_d     = '0;
            end
            FETCH: begin
                if (rd_valid) begin
                    data_d = rd_data;
                    cnt_d  = '0;
`ifdef LED_MATRIX_BLANK_EN
                    state_d = BLANK;
`else
                    state_d = SHOW;
`endif
                end
            end
`ifdef LED_MATRIX_BLANK_EN
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            SHOW: begin
                if (dwell_done) begin
                    state_d   = FETCH;
                    row_idx_d = row_idx_q + 3'd1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RESET_IDLE;
            end
        endcase

        // Pulse only on entry into FETCH for row 0, not on wait cycles.
        frame_start_d = (state_d == FETCH) && (state_q != FETCH) && (row_idx_d == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RESET_IDLE;
            row_idx_q      <= 3'd0;
            cnt_q          <= '0;
            buf_sel_q      <= 1'b0;
            swap_pending_q <= 1'b0;
            rd_req_q       <= 1'b0;
            rd_addr_q      <= 4'd0;
            swap_ack_q     <= 1'b0;
            frame_start_q  <= 1'b0;
            row_q          <= 8'd0;
            col_q          <= 8'd0;
        end else begin
            state_q        <= state_d;
            row_idx_q      <= row_idx_d;
            cnt_q          <= cnt_d;
            buf_sel_q      <= buf_sel_d;
            swap_pending_q <= swap_pending_d;
            rd_req_q       <= (state_d == FETCH);
            rd_addr_q      <= {buf_sel_d, row_idx_d};
            swap_ack_q     <= swap_now;
            frame_start_q  <= frame_start_d;
            row_q          <= (state_d == SHOW) ? (8'd1 << row_idx_d) : 8'd0;
            col_q          <= (state_d == SHOW) ? data_d : 8'd0;
        end
    end

    // Fetched row pixels; only ever observed through col_q, so no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign rd_req      = rd_req_q;
    assign rd_addr     = rd_addr_q;
    assign swap_ack    = swap_ack_q;
    assign buf_sel     = buf_sel_q;
    assign frame_start = frame_start_q;
    assign row         = row_q;
    assign col         = col_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Testbench for led_matrix_scanner with DWELL_CYCLES=4, BLANK_CYCLES=2.
// The memory model answers with rd_data = A0+row (buffer 0) or B0+row
// (buffer 1). Expected per-cycle output vectors are pushed to a queue as
// each step is driven and popped/compared once the DUT has produced them.

module tb_led_matrix_scanner;

    localparam int DW = 4;
    localparam int BW = 2;
`ifdef LED_MATRIX_BLANK_EN
    localparam int NB = BW;
`else
    localparam int NB = 0;
`endif

    // {frame_start, swap_ack, buf_sel, rd_req, rd_addr[3:0], row[7:0], col[7:0]}
    localparam logic [23:0] M_FULL   = 24'hFFFFFF;
    localparam logic [23:0] M_NOADDR = 24'hF0FFFF;

    logic       clk;
    logic       rst;
    logic       rd_req;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       swap_req;
    logic       swap_ack;
    logic       buf_sel;
    logic       frame_start;
    logic [7:0] row;
    logic [7:0] col;

    logic [23:0] exp_q[$];
    logic [23:0] msk_q[$];
    int n_cmp = 0;
    int n_err = 0;

    led_matrix_scanner #(
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .buf_sel    (buf_sel),
        .frame_start(frame_start),
        .row        (row),
        .col        (col)
    );

    // Frame store model: buffer 1 rows read B0..B7, buffer 0 rows A0..A7.
    assign rd_data = (rd_addr[3] ? 8'hB0 : 8'hA0) | {5'd0, rd_addr[2:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic fs, input logic ack, input logic bs,
                                       input logic req, input logic [3:0] addr,
                                       input logic [7:0] r, input logic [7:0] c);
        return {fs, ack, bs, req, addr, r, c};
    endfunction

    task automatic cycle(input logic [23:0] e, input logic [23:0] m, input string tag);
        logic [23:0] ee;
        logic [23:0] mm;
        logic [23:0] obs;
        exp_q.push_back(e);
        msk_q.push_back(m);
        @(posedge clk);
        @(negedge clk);
        ee  = exp_q.pop_front();
        mm  = msk_q.pop_front();
        obs = {frame_start, swap_ack, buf_sel, rd_req, rd_addr, row, col};
        n_cmp++;
        assert ((obs & mm) === (ee & mm)) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (fs,ack,bs,req,addr|row|col)",
                   tag, obs & mm, ee & mm);
        end
        swap_req = 1'b0;
    endtask

    // One row: FETCH (1 + waits cycles), blank gap, then show_n lit cycles.
    // swap_bits bit j pulses swap_req so it is sampled at the end of lit cycle j.
    task automatic run_row(input int r, input logic bs, input int waits, input logic fs,
                           input logic ack, input int swap_bits, input int show_n);
        logic [3:0] addr;
        logic [7:0] onehot;
        logic [7:0] pix;
        addr   = {bs, 3'(r)};
        onehot = 8'd1 << r;
        pix    = (bs ? 8'hB0 : 8'hA0) | 8'(r);
        for (int i = 0; i <= waits; i++) begin
            cycle(mk((i == 0) && fs, (i == 0) && ack, bs, 1'b1, addr, 8'd0, 8'd0), M_FULL,
                  $sformatf("fetch_r%0d_b%0d_w%0d", r, bs, i));
            rd_valid = (i == waits);
        end
        rd_valid = 1'b1;
        for (int i = 0; i < NB; i++) begin
            cycle(mk(1'b0, 1'b0, bs, 1'b0, 4'd0, 8'd0, 8'd0), M_NOADDR,
                  $sformatf("blank_r%0d_b%0d_c%0d", r, bs, i));
        end
        for (int j = 0; j < show_n; j++) begin
            cycle(mk(1'b0, 1'b0, bs, 1'b0, 4'd0, onehot, pix), M_NOADDR,
                  $sformatf("show_r%0d_b%0d_c%0d", r, bs, j));
            if (swap_bits[j]) swap_req = 1'b1;
        end
    endtask

    task automatic run_frame(input logic bs, input logic ack, input int stall_row,
                             input int swap_row, input int swap_bits);
        for (int r = 0; r < 8; r++) begin
            run_row(r, bs, (r == stall_row) ? 3 : 0, r == 0, ack && (r == 0),
                    (r == swap_row) ? swap_bits : 0, DW);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rd_valid = 1'b1;
        swap_req = 1'b0;

        // Reset state.
        cycle(24'd0, M_FULL, "reset_0");
        cycle(24'd0, M_FULL, "reset_1");
        rst = 1'b0;

        // Frame 1: buffer 0, row 5 fetch stalled for 3 extra cycles.
        run_frame(1'b0, 1'b0, 5, -1, 0);

        // Frame 2: two swap requests during row 2 merge into one pending swap.
        run_frame(1'b0, 1'b0, -1, 2, 32'b0101);

        // Frame 3: swap visible at frame start; a request on the very last
        // lit cycle of row 7 swaps back at that same boundary.
        run_frame(1'b1, 1'b1, -1, 7, 32'b1000);

        // Frame 4: swap made pending in row 1, then reset mid-show of row 3.
        run_row(0, 1'b0, 0, 1'b1, 1'b1, 0, DW);
        run_row(1, 1'b0, 0, 1'b0, 1'b0, 32'b0001, DW);
        run_row(2, 1'b0, 0, 1'b0, 1'b0, 0, DW);
        run_row(3, 1'b0, 0, 1'b0, 1'b0, 0, 2);
        rst = 1'b1;
        cycle(24'd0, M_FULL, "reset_mid_show");
        rst = 1'b0;

        // Restart at row 0; the discarded swap must never appear.
        run_frame(1'b0, 1'b0, -1, -1, 0);
        run_row(0, 1'b0, 0, 1'b1, 1'b0, 0, DW);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
